// File: rtl/alien_pkg.sv
// Shared definitions for the alien formation: march states and formation
// geometry. The march controller and the sprite renderer both import this
// package so pitch and sprite sizes stay consistent between them.
package alien_pkg;

  // Formation shape and sprite geometry (pixels)
  localparam int COLS      = 11;
  localparam int ROWS      = 5;
  localparam int COL_PITCH = 24;
  localparam int ROW_PITCH = 20;
  localparam int ALIEN_W   = 16;
  localparam int ALIEN_H   = 12;

  // March motion and playfield limits (pixels)
  localparam int STEP_X  = 2;
  localparam int STEP_Y  = 8;
  localparam int X_MIN   = 0;
  localparam int X_MAX   = 639;
  localparam int BASE_X  = 100;
  localparam int BASE_Y  = 64;
  localparam int Y_LIMIT = 400;

  // Index widths for the column/row bound encoders
  localparam int COL_IDX_W = $clog2(COLS);
  localparam int ROW_IDX_W = $clog2(ROWS);

  // DROP_R / DROP_L: the next step is a drop; the suffix is the direction
  // the formation takes once the drop has been made.
  typedef enum logic [2:0] {
    MARCH_R = 3'd0,
    MARCH_L = 3'd1,
    DROP_R  = 3'd2,
    DROP_L  = 3'd3,
    HALT    = 3'd4
  } march_state_t;

  // Ticks per step: the march speeds up as aliens are destroyed.
  function automatic logic [5:0] march_period(input logic [5:0] alive_count);
    return 6'd1 + (alive_count >> 2);
  endfunction

endpackage

// File: rtl/alien_bound_find.sv
// Lowest / highest set-bit encoder.
// Ports:
//   vec  in  N   bit vector to scan
//   lo   out W   index of the lowest set bit (0 when none set)
//   hi   out W   index of the highest set bit (0 when none set)
//   any  out 1   at least one bit of vec is set
module alien_bound_find #(
  parameter int N = 11,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         any
);

  // Priority scans: descending pass leaves the lowest set index in lo,
  // ascending pass leaves the highest set index in hi.
  always_comb begin
    lo  = {W{1'b0}};
    hi  = {W{1'b0}};
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      lo = vec[i] ? W'(i) : lo;
    end
    for (int j = 0; j < N; j++) begin
      hi = vec[j] ? W'(j) : hi;
    end
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march sequencer: counts frame ticks, steps the formation
// right/left, drops it one row at each wall, and stops on invasion or when
// the wave is cleared. Cadence shortens as the live-alien count falls.
// Ports:
//   CLK, RESET    clock and synchronous active-high reset
//   frame_tick    one-cycle pulse per video frame
//   enable        march allowed; low freezes all state
//   col_alive     per-column liveness (bit c = column c has a live alien)
//   row_alive     per-row liveness (row 0 on top)
//   alive_count   number of live aliens
//   form_x/form_y formation origin (column 0 left edge, row 0 top edge)
//   dir           0 = right, 1 = left
//   step_strobe   one-cycle pulse aligned with each step's updated outputs
//   anim_frame    toggles on every step
//   invaded       sticky: formation bottom reached the invasion line
//   wave_clear    sticky: no live columns remain
module alien_march_ctrl
  import alien_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            frame_tick,
  input  logic            enable,
  input  logic [COLS-1:0] col_alive,
  input  logic [ROWS-1:0] row_alive,
  input  logic [5:0]      alive_count,
  output logic [9:0]      form_x,
  output logic [9:0]      form_y,
  output logic            dir,
  output logic            step_strobe,
  output logic            anim_frame,
  output logic            invaded,
  output logic            wave_clear
);

  march_state_t         state_r;
  logic [5:0]           tick_cnt_r;

  logic [COL_IDX_W-1:0] col_lo_s;
  logic [COL_IDX_W-1:0] col_hi_s;
  logic                 col_any_s;
  logic [ROW_IDX_W-1:0] row_lo_s;
  logic [ROW_IDX_W-1:0] row_hi_s;
  logic                 row_any_s;
  logic                 unused_s;

  logic [5:0]           period_s;
  logic [5:0]           tick_next_s;
  logic                 run_s;
  logic                 step_due_s;
  logic [10:0]          right_edge_s;
  logic [10:0]          left_edge_s;
  logic [10:0]          new_bottom_s;

  alien_bound_find #(.N(COLS), .W(COL_IDX_W)) u_col_bounds (
    .vec (col_alive),
    .lo  (col_lo_s),
    .hi  (col_hi_s),
    .any (col_any_s)
  );

  alien_bound_find #(.N(ROWS), .W(ROW_IDX_W)) u_row_bounds (
    .vec (row_alive),
    .lo  (row_lo_s),
    .hi  (row_hi_s),
    .any (row_any_s)
  );

  // Only the bottom row matters for the formation's vertical extent.
  assign unused_s = ^{row_lo_s, row_any_s};

  // Cadence and formation extents from the live inputs and current origin.
  // The period is taken from alive_count at each tick, so a sudden drop in
  // the count fires a step on the very next qualifying tick.
  always_comb begin
    period_s     = march_period(alive_count);
    tick_next_s  = tick_cnt_r + 6'd1;
    run_s        = enable && (state_r != HALT);
    step_due_s   = (tick_next_s >= period_s);
    right_edge_s = 11'(form_x) + 11'(col_hi_s) * 11'(COL_PITCH) + 11'(ALIEN_W - 1);
    left_edge_s  = 11'(form_x) + 11'(col_lo_s) * 11'(COL_PITCH);
    // Bottom edge after the pending drop has been applied
    new_bottom_s = 11'(form_y) + 11'(STEP_Y) + 11'(row_hi_s) * 11'(ROW_PITCH)
                 + 11'(ALIEN_H - 1);
  end

  // March state machine with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= MARCH_R;
      tick_cnt_r  <= 6'd0;
      form_x      <= 10'(BASE_X);
      form_y      <= 10'(BASE_Y);
      dir         <= 1'b0;
      step_strobe <= 1'b0;
      anim_frame  <= 1'b0;
      invaded     <= 1'b0;
      wave_clear  <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      if (run_s && !col_any_s) begin
        // Wave cleared: stop without taking any pending step
        state_r    <= HALT;
        wave_clear <= 1'b1;
      end else if (run_s && frame_tick) begin
        if (step_due_s) begin
          tick_cnt_r  <= 6'd0;
          step_strobe <= 1'b1;
          anim_frame  <= ~anim_frame;
          case (state_r)
            MARCH_R: begin
              // Hitting the wall consumes the step without moving
              if (right_edge_s + 11'(STEP_X) > 11'(X_MAX)) begin
                state_r <= DROP_L;
              end else begin
                form_x <= form_x + 10'(STEP_X);
              end
            end
            MARCH_L: begin
              if (left_edge_s < 11'(X_MIN + STEP_X)) begin
                state_r <= DROP_R;
              end else begin
                form_x <= form_x - 10'(STEP_X);
              end
            end
            DROP_R, DROP_L: begin
              form_y <= form_y + 10'(STEP_Y);
              dir    <= (state_r == DROP_L);
              if (new_bottom_s >= 11'(Y_LIMIT)) begin
                state_r <= HALT;
                invaded <= 1'b1;
              end else begin
                state_r <= (state_r == DROP_L) ? MARCH_L : MARCH_R;
              end
            end
            default: begin
              state_r <= HALT;
            end
          endcase
        end else begin
          tick_cnt_r <= tick_next_s;
        end
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed self-checking bench for alien_march_ctrl.
module tb_alien_march_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b1;
  logic [10:0] col_alive = 11'h7FF;
  logic [4:0]  row_alive = 5'h1F;
  logic [5:0]  alive_count = 6'd55;
  logic [9:0]  form_x;
  logic [9:0]  form_y;
  logic        dir;
  logic        step_strobe;
  logic        anim_frame;
  logic        invaded;
  logic        wave_clear;

  int errors = 0;
  int checks = 0;
  int drops  = 0;
  logic saw_304_clean;
  logic [9:0] prev_y;

  alien_march_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .col_alive   (col_alive),
    .row_alive   (row_alive),
    .alive_count (alive_count),
    .form_x      (form_x),
    .form_y      (form_y),
    .dir         (dir),
    .step_strobe (step_strobe),
    .anim_frame  (anim_frame),
    .invaded     (invaded),
    .wave_clear  (wave_clear)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns on a falling edge, with the reset state visible.
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    frame_tick = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // One frame tick; outputs of that tick are visible on return.
  task automatic do_tick();
    @(negedge CLK);
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) do_tick();
  endtask

  initial begin
    // ---- Reset state, full formation, period 14
    enable = 1'b1; col_alive = 11'h7FF; row_alive = 5'h1F; alive_count = 6'd55;
    do_reset();
    chk("rst_x", form_x, 32'd100);
    chk("rst_y", form_y, 32'd64);
    chk("rst_dir", dir, 32'd0);
    chk("rst_strobe", step_strobe, 32'd0);
    chk("rst_anim", anim_frame, 32'd0);
    chk("rst_inv", invaded, 32'd0);
    chk("rst_clear", wave_clear, 32'd0);
    do_ticks(13);
    chk("p14_no_step_x", form_x, 32'd100);
    chk("p14_no_step_strobe", step_strobe, 32'd0);
    do_tick();
    chk("p14_step_strobe", step_strobe, 32'd1);
    chk("p14_step_x", form_x, 32'd102);
    chk("p14_step_anim", anim_frame, 32'd1);
    @(negedge CLK);
    chk("p14_strobe_pulse", step_strobe, 32'd0);

    // ---- Period 1, full columns: right wall at 384
    alive_count = 6'd3;
    do_reset();
    do_ticks(142);
    chk("w11_x142", form_x, 32'd384);
    do_tick();
    chk("w11_wall_x", form_x, 32'd384);
    chk("w11_wall_strobe", step_strobe, 32'd1);
    chk("w11_wall_y", form_y, 32'd64);
    chk("w11_wall_dir", dir, 32'd0);
    do_tick();
    chk("w11_drop_y", form_y, 32'd72);
    chk("w11_drop_dir", dir, 32'd1);
    chk("w11_drop_x", form_x, 32'd384);
    do_tick();
    chk("w11_left_x", form_x, 32'd382);
    chk("w11_anim", anim_frame, 32'd1);

    // ---- Rightmost column dead (R=9): wall at 408
    col_alive = 11'h3FF;
    do_reset();
    do_ticks(154);
    chk("w10_x154", form_x, 32'd408);
    do_tick();
    chk("w10_wall_x", form_x, 32'd408);
    do_tick();
    chk("w10_drop_y", form_y, 32'd72);
    chk("w10_drop_dir", dir, 32'd1);

    // ---- Alive count drops mid-count: step on the next tick
    col_alive = 11'h7FF; alive_count = 6'd55;
    do_reset();
    do_ticks(5);
    chk("mid_no_step_x", form_x, 32'd100);
    alive_count = 6'd3;
    do_tick();
    chk("mid_step_x", form_x, 32'd102);

    // ---- Invasion: march and drop until the formation reaches the line
    do_reset();
    saw_304_clean = 1'b0;
    prev_y = form_y;
    for (int i = 0; i < 8000 && !invaded; i++) begin
      do_tick();
      if (form_y != prev_y) drops++;
      prev_y = form_y;
      if (form_y == 10'd304 && !invaded) saw_304_clean = 1'b1;
    end
    chk("inv_reached", invaded, 32'd1);
    chk("inv_y", form_y, 32'd312);
    chk("inv_drops", drops, 32'd31);
    chk("inv_304_clean", saw_304_clean, 32'd1);
    chk("inv_dir", dir, 32'd1);
    chk("inv_x", form_x, 32'd384);
    chk("inv_strobe", step_strobe, 32'd1);
    do_ticks(5);
    chk("halt_y", form_y, 32'd312);
    chk("halt_x", form_x, 32'd384);
    chk("halt_strobe", step_strobe, 32'd0);
    chk("halt_inv", invaded, 32'd1);

    // ---- Wave clear concurrent with a step-qualifying tick
    do_reset();
    do_ticks(3);
    chk("wc_pre_x", form_x, 32'd106);
    @(negedge CLK);
    col_alive = 11'h000;
    frame_tick = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    chk("wc_flag", wave_clear, 32'd1);
    chk("wc_strobe", step_strobe, 32'd0);
    chk("wc_x", form_x, 32'd106);
    chk("wc_anim", anim_frame, 32'd1);
    col_alive = 11'h7FF;
    do_ticks(4);
    chk("wc_halt_x", form_x, 32'd106);
    chk("wc_sticky", wave_clear, 32'd1);

    // ---- Enable low freezes the count
    alive_count = 6'd55;
    do_reset();
    do_ticks(5);
    enable = 1'b0;
    do_ticks(20);
    chk("en_frozen_x", form_x, 32'd100);
    chk("en_frozen_strobe", step_strobe, 32'd0);
    enable = 1'b1;
    do_ticks(8);
    chk("en_resume_no_step", form_x, 32'd100);
    do_tick();
    chk("en_resume_step_x", form_x, 32'd102);
    chk("en_resume_strobe", step_strobe, 32'd1);

    // ---- RESET together with a step-qualifying tick
    do_ticks(13);
    chk("rs_pre_x", form_x, 32'd102);
    @(negedge CLK);
    frame_tick = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    frame_tick = 1'b0;
    RESET = 1'b0;
    chk("rs_x", form_x, 32'd100);
    chk("rs_y", form_y, 32'd64);
    chk("rs_dir", dir, 32'd0);
    chk("rs_strobe", step_strobe, 32'd0);
    chk("rs_anim", anim_frame, 32'd0);
    do_ticks(13);
    chk("rs_cnt_cleared_x", form_x, 32'd100);
    do_tick();
    chk("rs_first_step_x", form_x, 32'd102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alien_march_ctrl.md
Name: alien_march_ctrl

Overview:
Sequences the alien formation's march across the playfield: right-steps, then a drop at the wall, then left-steps, and so on. It owns the formation origin (form_x, form_y), the march direction, the step cadence and the animation frame. The cadence speeds up as the live-alien count falls. It sits between the game frame-tick source and the alien grid/sprite renderer, which draws each alien at origin + column/row pitch, and it consumes per-column/per-row liveness from the alien grid.

Parameters:
COLS, 11, columns in formation
ROWS, 5, rows in formation
COL_PITCH, 24, pixels between column origins
ROW_PITCH, 20, pixels between row origins
ALIEN_W, 16, sprite width in pixels
ALIEN_H, 12, sprite height in pixels
STEP_X, 2, horizontal pixels per step
STEP_Y, 8, vertical pixels per drop
X_MIN, 0, leftmost legal pixel
X_MAX, 639, rightmost legal pixel
BASE_X, 100, form_x after reset
BASE_Y, 64, form_y after reset
Y_LIMIT, 400, invasion line (bottom pixel)

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high
frame_tick  in  1  one-CLK pulse per video frame (~60 Hz)
enable  in  1  march allowed; low freezes all state
col_alive  in  COLS  bit c = column c has at least one live alien
row_alive  in  ROWS  bit r = row r has at least one live alien (row 0 on top)
alive_count  in  6  live aliens, 0..55
form_x  out  10  formation origin X (column 0 left edge)
form_y  out  10  formation origin Y (row 0 top edge)
dir  out  1  0 = right, 1 = left
step_strobe  out  1  one-CLK pulse on every step, horizontal or drop
anim_frame  out  1  toggles on every step
invaded  out  1  sticky; formation bottom reached Y_LIMIT
wave_clear  out  1  sticky; col_alive == 0

Behaviour:
- Clock CLK; reset RESET, synchronous, active-high.
- Reset values: form_x=BASE_X, form_y=BASE_Y, dir=0, step_strobe=0, anim_frame=0, invaded=0, wave_clear=0, tick_cnt=0, state=MARCH_R.
- States:
  - MARCH_R and MARCH_L: horizontal stepping.
  - DROP_R and DROP_L: the next step is a drop; the suffix gives the direction after the drop.
  - HALT: terminal until RESET.
- Period: period = 1 + (alive_count >> 2), 6-bit. Examples: 55 gives 14; 3 gives 1.
- Tick counting:
  - On frame_tick with enable=1 and state != HALT, tick_cnt increments.
  - When tick_cnt+1 >= period, a step fires on that same cycle and tick_cnt clears to 0.
  - tick_cnt is compared against the period latched at that tick. If alive_count drops mid-count, a step fires immediately when tick_cnt+1 >= the new period.
- Bounds: L = lowest set index of col_alive, R = highest set index, B = highest set index of row_alive. All are combinational from the current inputs.
- Geometry is computed at 11-bit width (no wrap):
  - right edge = form_x + R*COL_PITCH + ALIEN_W - 1
  - left edge = form_x + L*COL_PITCH
  - bottom = form_y + B*ROW_PITCH + ALIEN_H - 1
- Step in MARCH_R:
  - If right edge + STEP_X > X_MAX, go to DROP_L and do not move.
  - Otherwise form_x += STEP_X.
- Step in MARCH_L:
  - If left edge < X_MIN + STEP_X, go to DROP_R and do not move.
  - Otherwise form_x -= STEP_X.
  - The wall check itself counts as a step: step_strobe pulses and anim_frame toggles.
- Step in DROP_x:
  - form_y += STEP_Y.
  - dir is set to the suffix direction; state becomes MARCH_x.
  - If the new bottom >= Y_LIMIT, go to HALT and set invaded=1 on the next cycle.
- step_strobe is registered: high for exactly the cycle after the step decision, aligned with the updated form_x/form_y/anim_frame.
- wave_clear:
  - col_alive==0 in any non-HALT state goes to HALT with wave_clear=1 on the next cycle.
  - This takes priority over a concurrent step; no step is taken.
- HALT: all outputs hold; frame_tick is ignored.
- enable=0: tick_cnt, state and outputs hold; frame_tick is ignored. Reasserting enable resumes the count.
- RESET mid-step: RESET wins; all state returns to reset values.
- Outputs are glitch-free registers.

Decomposition:
- Shared package alien_pkg holds:
  - march_state_t enum (MARCH_R, MARCH_L, DROP_R, DROP_L, HALT);
  - COLS, ROWS, pitch and sprite-size constants, so the renderer shares them.
- Sub-module alien_bound_find: parameterised N-bit lowest/highest set-bit encoder with an any-set flag.
  - Instantiated twice: on col_alive for L/R, and on row_alive for B.

Test Plan:
- Reset, all alive (count 55, col_alive=0x7FF, row_alive=0x1F) -> form_x=100, form_y=64, dir=0. After 13 frame_ticks no step; on the 14th tick step_strobe pulses, form_x=102, anim_frame=1.
- Count 3 (period 1), all columns alive, march right -> each tick steps. form_x reaches 384 after 142 steps. The 143rd step keeps form_x=384, state DROP_L. The 144th step gives form_y=72, dir=1, form_x=384. The 145th gives form_x=382.
- Same as above but col_alive=0x3FF (R=9) -> the wall is reached at form_x=408 instead of 384.
- Count 3, form_y pushed by repeated drops with row_alive=0x1F -> the drop making form_y+91 >= 400 (form_y=312) asserts invaded next cycle. Further ticks are ignored.
- col_alive driven to 0 in the same cycle as a step-qualifying tick -> no step, wave_clear=1 next cycle, form_x unchanged.
- enable low for 20 ticks mid-count, then RESET asserted during a step cycle -> counter frozen while disabled; RESET restores form_x=100, form_y=64, dir=0, outputs cleared.
